// File: rtl/write_req_issuer.sv
// write_req_issuer: buffers line-write entries from the write engine and
// issues them as registered CCI-P channel-1 write requests, tracking
// issued-but-unacknowledged writes until the run drains.
// Optional feature macro: WR_ISSUER_FENCE_EN -- when defined, a write fence
// is issued on entering DRAIN and DONE also waits for its response.
module write_req_issuer #(
  parameter int FIFO_DEPTH      = 8,
  parameter int MAX_OUTSTANDING = 64,
  parameter int CL_ADDR_W       = 42,
  parameter int CL_DATA_W       = 512
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [31:0]          i_wr_total,
  input  logic                 i_wr_valid,
  input  logic [CL_ADDR_W-1:0] i_wr_addr,
  input  logic [CL_DATA_W-1:0] i_wr_data,
  input  logic                 i_c1TxAlmFull,
  input  logic                 i_c1_rsp_valid,
  input  logic [3:0]           i_c1_rsp_type,
  output logic                 o_stall,
  output logic                 o_c1_tx_valid,
  output logic [3:0]           o_c1_tx_type,
  output logic [CL_ADDR_W-1:0] o_c1_tx_addr,
  output logic [CL_DATA_W-1:0] o_c1_tx_data,
  output logic [15:0]          o_c1_tx_mdata,
  output logic [7:0]           o_outstanding,
  output logic [31:0]          o_issued_cnt,
  output logic                 o_wr_done,
  output logic                 o_overflow
);

  localparam int             PTR_W      = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_CNT  = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0] STALL_FREE = (PTR_W+1)'(3);
  localparam logic [7:0]     MAX_OUT    = 8'(MAX_OUTSTANDING);
  localparam logic [3:0]     TYPE_WR    = 4'h0;
  localparam logic [3:0]     TYPE_FENCE = 4'h4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic [CL_ADDR_W-1:0] r_fifoAddr [FIFO_DEPTH];
  logic [CL_DATA_W-1:0] r_fifoData [FIFO_DEPTH];
  logic [PTR_W:0]       r_wrPtr;
  logic [PTR_W:0]       r_rdPtr;
  logic [31:0]          r_total;
  logic [31:0]          r_issuedCnt;
  logic [7:0]           r_outstanding;
  logic                 r_stall;
  logic                 r_overflow;

  logic [PTR_W:0]       w_count;
  logic [PTR_W:0]       w_countNext;
  logic [PTR_W:0]       w_freeNext;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_accept;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_issue;
  logic                 w_rspDec;
  logic                 w_fenceIssue;
  logic                 w_fenceDone;
  logic [CL_ADDR_W-1:0] w_headAddr;
  logic [CL_DATA_W-1:0] w_headData;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_count     = r_wrPtr - r_rdPtr;
  assign w_full      = (w_count == DEPTH_CNT);
  assign w_empty     = (w_count == '0);
  assign w_headAddr  = r_fifoAddr[r_rdPtr[PTR_W-1:0]];
  assign w_headData  = r_fifoData[r_rdPtr[PTR_W-1:0]];

  // Entries are only taken while the run is live; later ones vanish quietly.
  assign w_accept    = i_wr_valid && ((r_state == ST_IDLE) || (r_state == ST_RUN));
  assign w_push      = w_accept && !w_full;

  // Issue gating also stops at the latched total so extra entries cannot overshoot it.
  assign w_issue     = (r_state == ST_RUN) && !w_empty && !i_c1TxAlmFull &&
                       (r_outstanding < MAX_OUT) && (r_issuedCnt != r_total);
  assign w_pop       = w_issue;

  assign w_countNext = w_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
  assign w_freeNext  = DEPTH_CNT - w_countNext;

  // A stray write response with nothing outstanding must not wrap the counter.
  assign w_rspDec    = i_c1_rsp_valid && (i_c1_rsp_type == TYPE_WR) && (r_outstanding != '0);

`ifdef WR_ISSUER_FENCE_EN
  logic r_fenceSent;
  logic r_fenceAck;

  assign w_fenceIssue = (r_state == ST_DRAIN) && !r_fenceSent && !i_c1TxAlmFull;
  assign w_fenceDone  = r_fenceAck;

  // Track the single drain fence: sent once, then wait for its response.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_fenceSent <= 1'b0;
      r_fenceAck  <= 1'b0;
    end else begin
      if (w_fenceIssue) r_fenceSent <= 1'b1;
      if (i_c1_rsp_valid && (i_c1_rsp_type == TYPE_FENCE) && r_fenceSent) r_fenceAck <= 1'b1;
    end
  end
`else
  assign w_fenceIssue = 1'b0;
  assign w_fenceDone  = 1'b1;
`endif

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_reset) r_state <= ST_IDLE;
    else          r_state <= w_nextState;
  end

  // Run sequencing: one IDLE cycle, issue until the total, drain, then park.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      ST_IDLE:  w_nextState = ST_RUN;
      ST_RUN:   if (r_issuedCnt == r_total) w_nextState = ST_DRAIN;
      ST_DRAIN: if ((r_outstanding == '0) && w_fenceDone) w_nextState = ST_DONE;
      ST_DONE:  w_nextState = ST_DONE;
      default:  w_nextState = ST_IDLE;
    endcase
  end

  // Latch the expected write count during the IDLE cycle only.
  always_ff @(posedge i_clk) begin
    if (!i_reset)                r_total <= '0;
    else if (r_state == ST_IDLE) r_total <= i_wr_total;
  end

  // Buffer storage carries no reset; validity is tracked by the pointers.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_fifoAddr[r_wrPtr[PTR_W-1:0]] <= i_wr_addr;
      r_fifoData[r_wrPtr[PTR_W-1:0]] <= i_wr_data;
    end
  end

  // Buffer pointers; reset discards anything still queued.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + (PTR_W+1)'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + (PTR_W+1)'(1);
    end
  end

  // Stall leaves room for the engine's two in-flight entries plus this register's delay.
  always_ff @(posedge i_clk) begin
    if (!i_reset) r_stall <= 1'b1;
    else          r_stall <= (w_freeNext <= STALL_FREE);
  end

  // Sticky record of an entry lost to a full buffer.
  always_ff @(posedge i_clk) begin
    if (!i_reset)                r_overflow <= 1'b0;
    else if (w_accept && w_full) r_overflow <= 1'b1;
  end

  // Registered channel-1 request: a one-cycle pulse per write or fence.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      o_c1_tx_valid <= 1'b0;
      o_c1_tx_type  <= '0;
      o_c1_tx_addr  <= '0;
      o_c1_tx_data  <= '0;
      o_c1_tx_mdata <= '0;
    end else if (w_issue) begin
      o_c1_tx_valid <= 1'b1;
      o_c1_tx_type  <= TYPE_WR;
      o_c1_tx_addr  <= w_headAddr;
      o_c1_tx_data  <= w_headData;
      o_c1_tx_mdata <= r_issuedCnt[15:0];
    end else if (w_fenceIssue) begin
      o_c1_tx_valid <= 1'b1;
      o_c1_tx_type  <= TYPE_FENCE;
      o_c1_tx_addr  <= '0;
      o_c1_tx_data  <= '0;
      o_c1_tx_mdata <= r_issuedCnt[15:0];
    end else begin
      o_c1_tx_valid <= 1'b0;
    end
  end

  // Count issued line writes, saturating rather than wrapping.
  always_ff @(posedge i_clk) begin
    if (!i_reset)                               r_issuedCnt <= '0;
    else if (w_issue && (r_issuedCnt != '1))    r_issuedCnt <= r_issuedCnt + 32'd1;
  end

  // Outstanding writes: issue adds, write response removes, both together cancel.
  always_ff @(posedge i_clk) begin
    if (!i_reset)                    r_outstanding <= '0;
    else if (w_issue && !w_rspDec)   r_outstanding <= r_outstanding + 8'd1;
    else if (!w_issue && w_rspDec)   r_outstanding <= r_outstanding - 8'd1;
  end

  assign o_stall       = r_stall;
  assign o_outstanding = r_outstanding;
  assign o_issued_cnt  = r_issuedCnt;
  assign o_wr_done     = (r_state == ST_DONE);
  assign o_overflow    = r_overflow;

endmodule

// File: doc/write_req_issuer.md
WRITE_REQ_ISSUER -- requirements
Module: write_req_issuer

Interface
REQ-001 Parameter FIFO_DEPTH, default 8, SHALL set the write-entry buffer depth in entries; legal values are powers of two, 4 or more.
REQ-002 Parameter MAX_OUTSTANDING, default 64, SHALL set the cap on issued-but-unacknowledged line writes; legal range is 1 to 255.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  in  1  SHALL be the synchronous, active-low reset.
REQ-005 wr_total  in  32  SHALL be the number of line writes expected for the run; sampled in IDLE only.
REQ-006 wr_valid  in  1  SHALL qualify a write entry from the write engine.
REQ-007 wr_addr  in  t_cci_clAddr  SHALL carry the cache-line address of the entry.
REQ-008 wr_data  in  t_cciClData  SHALL carry the 512-bit line payload of the entry.
REQ-009 c1TxAlmFull  in  1  SHALL be the CCI-P channel-1 almost-full back-pressure.
REQ-010 c1_rsp_valid  in  1  SHALL qualify a channel-1 write response.
REQ-011 c1_rsp_type  in  4  SHALL carry the response type: 4'h0 is a line-write response, 4'h4 is a fence response.
REQ-012 stall  out  1  SHALL be back-pressure to the write engine.
REQ-013 c1_tx_valid, c1_tx_type(4), c1_tx_addr, c1_tx_data, c1_tx_mdata(16)  out  SHALL form the registered channel-1 request.
REQ-014 outstanding  out  8  SHALL be the number of line writes issued and not yet acknowledged.
REQ-015 issued_cnt  out  32  SHALL be the number of line writes issued this run.
REQ-016 wr_done  out  1  SHALL be high while in DONE.
REQ-017 overflow  out  1  SHALL be a sticky flag for an entry dropped on a full buffer.

Function
REQ-018 The block SHALL run the states IDLE, RUN, DRAIN, DONE, with these transitions:
- IDLE to RUN on the first cycle after reset deasserts, latching wr_total.
- RUN to DRAIN when issued_cnt equals the latched total.
- DRAIN to DONE when outstanding is 0 (and, with the fence compiled in, the fence response has arrived).
- DONE is held until reset.
REQ-019 If the latched total is 0, the block SHALL go RUN, then DRAIN, then DONE in consecutive cycles with no requests issued.
REQ-020 An entry with wr_valid high SHALL be written to the FIFO on the same edge when the FIFO is not full.
- If the FIFO is full, the entry SHALL be dropped and overflow SHALL be set.
REQ-021 stall SHALL be a registered output, high when free FIFO slots are 3 or fewer (occupancy counted after this cycle's push and pop).
- This covers the write engine's 2-cycle in-flight skid plus 1 cycle of stall register delay.
REQ-022 A line write SHALL issue on a clock edge when all of the following hold: state RUN, FIFO not empty, c1TxAlmFull low, outstanding < MAX_OUTSTANDING.
- On issue: pop the FIFO head, and register c1_tx_valid=1, c1_tx_type=4'h0, address and data from the head, and c1_tx_mdata = issued_cnt[15:0].
REQ-023 c1_tx_valid SHALL be high for exactly one cycle per request; it is low otherwise.
REQ-024 Minimum latency SHALL be 2 edges: wr_valid sampled at edge E (empty FIFO, no back-pressure) gives c1_tx_valid high after edge E+1.
REQ-025 issued_cnt SHALL increment by 1 per issued line write and saturate at 2^32-1.
REQ-026 outstanding SHALL be updated as follows:
- +1 on a line-write issue.
- -1 on a 4'h0 response.
- Unchanged when both occur in the same cycle.
REQ-027 A 4'h0 response received while outstanding is 0 SHALL be ignored; the counter SHALL NOT wrap.
REQ-028 Entries arriving after RUN has been left SHALL be dropped without setting overflow.
REQ-029 c1TxAlmFull rising SHALL block issue on the same edge; the request already registered SHALL still be presented.

Reset
REQ-030 While reset is low, the following SHALL be cleared on the next edge:
- state to IDLE;
- FIFO pointers and outstanding to 0;
- issued_cnt to 0;
- c1_tx_valid, wr_done, overflow to 0.
REQ-031 While reset is low, stall SHALL be 1; c1_tx_addr, c1_tx_data, c1_tx_mdata and c1_tx_type SHALL be 0.
REQ-032 Reset asserted mid-run SHALL discard buffered entries and outstanding count without issuing further requests.

Configuration
REQ-033 The fence feature SHALL be controlled by macro WR_ISSUER_FENCE_EN.
- Defined: on entering DRAIN, issue one request with c1_tx_type=4'h4 (address and data 0) as soon as c1TxAlmFull is low; DONE additionally requires a 4'h4 response.
- Undefined: no fence is issued and 4'h4 responses are ignored.

Verification
REQ-034 Scenario: wr_total=4, 4 back-to-back entries, no back-pressure, each response returned 5 cycles after its request -> 4 requests with mdata 0..3 and addresses in order; outstanding peaks at 4; wr_done high after the last response.
REQ-035 Scenario: 20 back-to-back entries with c1TxAlmFull held high -> stall high by the 5th entry; overflow stays 0; c1_tx_valid stays 0 until c1TxAlmFull drops; then 20 requests issue.
REQ-036 Scenario: MAX_OUTSTANDING=2, responses withheld -> exactly 2 requests issue; the 3rd issues one edge after the first response.
REQ-037 Scenario: issue and response in the same cycle with outstanding=3 -> outstanding stays 3.
REQ-038 Scenario: reset pulled low with 5 entries buffered -> no further c1_tx_valid; counters 0; state IDLE.
REQ-039 Scenario: WR_ISSUER_FENCE_EN defined, wr_total=2 -> a fence follows the 2nd write; wr_done stays low until the 4'h4 response arrives.
